// File: rtl/fire4_squeeze_wfetch_if.sv
// Weight stream from the fire4_squeeze ROM address sequencer to the MAC array.
// The controller drives the ROM address and stream qualifiers; the MAC array returns ready.
interface fire4_squeeze_wfetch_if #(
  parameter int unsigned ADDR   = 10,
  parameter int unsigned PASS_W = 12
);
  logic [ADDR-1:0]   rom_addr_c;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic              w_end;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output rom_addr_c,
    output w_valid,
    output w_last,
    output w_end,
    output pass_idx,
    input  w_ready
  );

  modport slave (
    input  rom_addr_c,
    input  w_valid,
    input  w_last,
    input  w_end,
    input  pass_idx,
    output w_ready
  );
endinterface

// File: rtl/fire4_squeeze_wfetch_ctrl.sv
// Read-address sequencer for the fire4_squeeze weight ROM bank: streams one 32-lane word
// per cycle over valid/ready, repeating the sweep per pass, hiding the 1-cycle ROM latency.
module fire4_squeeze_wfetch_ctrl #(
  parameter int unsigned ADDR   = 10,
  parameter int unsigned PASS_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [ADDR-1:0]   cfg_len_m1_i,
  input  logic [PASS_W-1:0] cfg_passes_m1_i,
  fire4_squeeze_wfetch_if.master w_if,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR-1:0]   out_addr_q, out_addr_d;
  logic [ADDR-1:0]   len_q, len_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wrap_c;
  logic              accept_c;
  logic [ADDR-1:0]   next_addr_c;
  logic [ADDR-1:0]   rom_addr_c;

  assign wrap_c      = (out_addr_q == len_q);
  assign next_addr_c = wrap_c ? '0 : out_addr_q + ADDR'(1);
  assign accept_c    = valid_q & w_if.w_ready;

  // Re-issue the presented address under stall so the registered ROM output holds.
  always_comb begin
    rom_addr_c = '0;
    if (state_q == S_RUN && valid_q) begin
      rom_addr_c = accept_c ? next_addr_c : out_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_addr_q <= '0;
      len_q      <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      end_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_addr_q <= out_addr_d;
      len_q      <= len_d;
      pass_q     <= pass_d;
      passes_q   <= passes_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      end_q      <= end_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_addr_d = out_addr_q;
    len_d      = len_q;
    pass_d     = pass_q;
    passes_d   = passes_q;
    valid_d    = valid_q;
    done_d     = 1'b0;

    if (flush_i) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      pass_d     = '0;
      out_addr_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start_i && !done_q) begin
            state_d    = S_RUN;
            len_d      = cfg_len_m1_i;
            passes_d   = cfg_passes_m1_i;
            out_addr_d = '0;
            pass_d     = '0;
            valid_d    = 1'b1;
          end
        end
        S_RUN: begin
          if (!valid_q) begin
            valid_d    = 1'b1;
            out_addr_d = '0;
          end else if (accept_c) begin
            if (end_q) begin
              state_d    = S_IDLE;
              valid_d    = 1'b0;
              done_d     = 1'b1;
              pass_d     = '0;
              out_addr_d = '0;
            end else begin
              out_addr_d = next_addr_c;
              if (wrap_c) pass_d = pass_q + PASS_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stream qualifiers are precomputed from next-state values so they leave registers.
  always_comb begin
    last_d = valid_d && (out_addr_d == len_d);
    end_d  = last_d && (pass_d == passes_d);
    busy_d = (state_d == S_RUN);
  end

  assign w_if.rom_addr_c = rom_addr_c;
  assign w_if.w_valid    = valid_q;
  assign w_if.w_last     = last_q;
  assign w_if.w_end      = end_q;
  assign w_if.pass_idx   = pass_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_fire4_squeeze_wfetch_ctrl.sv
// Directed vector bench for fire4_squeeze_wfetch_ctrl with a 1-cycle registered ROM model.
module tb_fire4_squeeze_wfetch_ctrl;
  localparam int unsigned ADDR   = 10;
  localparam int unsigned PASS_W = 12;

  typedef struct packed {
    logic              v;
    logic [ADDR-1:0]   a;
    logic              l;
    logic              e;
    logic [PASS_W-1:0] p;
    logic              b;
    logic              d;
  } out_t;

  typedef struct {
    logic              st;
    logic              fl;
    logic              rdy;
    logic [ADDR-1:0]   len;
    logic [PASS_W-1:0] ps;
    out_t              exp;
    logic [ADDR-1:0]   word;
  } row_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              flush;
  logic [ADDR-1:0]   cfg_len;
  logic [PASS_W-1:0] cfg_ps;
  logic              busy;
  logic              done;
  logic [15:0]       rom_q;

  int checks = 0;
  int errors = 0;
  row_t vec[$];

  fire4_squeeze_wfetch_if #(.ADDR(ADDR), .PASS_W(PASS_W)) bus ();

  fire4_squeeze_wfetch_ctrl #(.ADDR(ADDR), .PASS_W(PASS_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .flush_i         (flush),
    .cfg_len_m1_i    (cfg_len),
    .cfg_passes_m1_i (cfg_ps),
    .w_if            (bus.master),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [ADDR-1:0] addr);
    return 16'h5A00 ^ {6'd0, addr};
  endfunction

  always @(posedge clk) rom_q <= rom_f(bus.rom_addr_c);

  function automatic void r(input logic st, input logic fl, input logic rdy, input int len,
                            input int ps, input logic v, input int a, input int w,
                            input logic l, input logic e, input int p, input logic b,
                            input logic d);
    row_t x;
    x.st   = st;
    x.fl   = fl;
    x.rdy  = rdy;
    x.len  = ADDR'(len);
    x.ps   = PASS_W'(ps);
    x.exp  = '{v: v, a: ADDR'(a), l: l, e: e, p: PASS_W'(p), b: b, d: d};
    x.word = ADDR'(w);
    vec.push_back(x);
  endfunction

  task automatic check_out(input out_t exp, input string name);
    out_t got;
    got = '{v: bus.w_valid, a: bus.rom_addr_c, l: bus.w_last, e: bus.w_end,
            p: bus.pass_idx, b: busy, d: done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got v=%0b addr=%0d last=%0b end=%0b pass=%0d busy=%0b done=%0b want v=%0b addr=%0d last=%0b end=%0b pass=%0d busy=%0b done=%0b",
               name, got.v, got.a, got.l, got.e, got.p, got.b, got.d,
               exp.v, exp.a, exp.l, exp.e, exp.p, exp.b, exp.d);
    end
  endtask

  task automatic apply_rows();
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      start         = vec[i].st;
      flush         = vec[i].fl;
      bus.w_ready   = vec[i].rdy;
      cfg_len       = vec[i].len;
      cfg_ps        = vec[i].ps;
      #1;
      check_out(vec[i].exp, $sformatf("row%0d", i));
      if (vec[i].exp.v) begin
        checks++;
        if (rom_q !== rom_f(vec[i].word)) begin
          errors++;
          $display("FAIL row%0d_word got %h want %h", i, rom_q, rom_f(vec[i].word));
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    bus.w_ready = 1'b0;
    cfg_len     = '0;
    cfg_ps      = '0;
    repeat (2) @(negedge clk);
    #1;
    check_out('0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // len 3, single pass; cfg changes mid-run are ignored
    r(1,0,1,3,0, 0,0,0,0,0,0,0,0);
    r(0,0,1,9,9, 1,1,0,0,0,0,1,0);
    r(0,0,1,9,9, 1,2,1,0,0,0,1,0);
    r(0,0,1,9,9, 1,3,2,0,0,0,1,0);
    r(0,0,1,9,9, 1,0,3,1,1,0,1,0);
    r(0,0,1,0,0, 0,0,0,0,0,0,0,1);
    r(0,0,1,0,0, 0,0,0,0,0,0,0,0);
    // len 2, three passes, no bubbles at pass boundaries
    r(1,0,1,2,2, 0,0,0,0,0,0,0,0);
    r(0,0,1,2,2, 1,1,0,0,0,0,1,0);
    r(0,0,1,2,2, 1,2,1,0,0,0,1,0);
    r(0,0,1,2,2, 1,0,2,1,0,0,1,0);
    r(0,0,1,2,2, 1,1,0,0,0,1,1,0);
    r(0,0,1,2,2, 1,2,1,0,0,1,1,0);
    r(0,0,1,2,2, 1,0,2,1,0,1,1,0);
    r(0,0,1,2,2, 1,1,0,0,0,2,1,0);
    r(0,0,1,2,2, 1,2,1,0,0,2,1,0);
    r(0,0,1,2,2, 1,0,2,1,1,2,1,0);
    r(0,0,1,2,2, 0,0,0,0,0,0,0,1);
    r(0,0,1,2,2, 0,0,0,0,0,0,0,0);
    // len 7, stall for 3 cycles on word 4
    r(1,0,1,7,0, 0,0,0,0,0,0,0,0);
    r(0,0,1,7,0, 1,1,0,0,0,0,1,0);
    r(0,0,1,7,0, 1,2,1,0,0,0,1,0);
    r(0,0,1,7,0, 1,3,2,0,0,0,1,0);
    r(0,0,1,7,0, 1,4,3,0,0,0,1,0);
    r(0,0,0,7,0, 1,4,4,0,0,0,1,0);
    r(0,0,0,7,0, 1,4,4,0,0,0,1,0);
    r(0,0,0,7,0, 1,4,4,0,0,0,1,0);
    r(0,0,1,7,0, 1,5,4,0,0,0,1,0);
    r(0,0,1,7,0, 1,6,5,0,0,0,1,0);
    r(0,0,1,7,0, 1,7,6,0,0,0,1,0);
    r(0,0,1,7,0, 1,0,7,1,1,0,1,0);
    r(0,0,1,7,0, 0,0,0,0,0,0,0,1);
    r(0,0,1,7,0, 0,0,0,0,0,0,0,0);
    // len 4, 4 passes, flush on word 2 of pass 1, then clean restart
    r(1,0,1,4,3, 0,0,0,0,0,0,0,0);
    r(0,0,1,4,3, 1,1,0,0,0,0,1,0);
    r(0,0,1,4,3, 1,2,1,0,0,0,1,0);
    r(0,0,1,4,3, 1,3,2,0,0,0,1,0);
    r(0,0,1,4,3, 1,4,3,0,0,0,1,0);
    r(0,0,1,4,3, 1,0,4,1,0,0,1,0);
    r(0,0,1,4,3, 1,1,0,0,0,1,1,0);
    r(0,0,1,4,3, 1,2,1,0,0,1,1,0);
    r(0,1,1,4,3, 1,3,2,0,0,1,1,0);
    r(0,0,1,4,3, 0,0,0,0,0,0,0,0);
    r(1,0,1,1,0, 0,0,0,0,0,0,0,0);
    r(0,0,1,1,0, 1,1,0,0,0,0,1,0);
    r(0,0,1,1,0, 1,0,1,1,1,0,1,0);
    r(0,0,1,1,0, 0,0,0,0,0,0,0,1);
    r(1,1,1,1,0, 0,0,0,0,0,0,0,0);
    r(0,0,1,1,0, 0,0,0,0,0,0,0,0);
    // start while busy and in the done cycle is ignored
    r(1,0,1,1,1, 0,0,0,0,0,0,0,0);
    r(1,0,1,5,5, 1,1,0,0,0,0,1,0);
    r(0,0,1,5,5, 1,0,1,1,0,0,1,0);
    r(1,0,1,5,5, 1,1,0,0,0,1,1,0);
    r(0,0,1,5,5, 1,0,1,1,1,1,1,0);
    r(1,0,1,5,5, 0,0,0,0,0,0,0,1);
    r(0,0,1,5,5, 0,0,0,0,0,0,0,0);
    r(1,0,1,0,0, 0,0,0,0,0,0,0,0);
    r(0,0,1,0,0, 1,0,0,1,1,0,1,0);
    r(0,0,1,0,0, 0,0,0,0,0,0,0,1);
    r(0,0,1,0,0, 0,0,0,0,0,0,0,0);
    apply_rows();

    // async reset mid-pass with random back-pressure
    start   = 1'b1;
    cfg_len = ADDR'(9);
    cfg_ps  = PASS_W'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.w_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #1;
    check_out('{v: 1'b1, a: bus.rom_addr_c, l: 1'b0, e: 1'b0, p: '0, b: 1'b1, d: 1'b0},
              "pre_reset_busy");
    #1;
    rst_n = 1'b0;
    #1;
    check_out('0, "async_reset_mid");
    @(negedge clk);
    #1;
    check_out('0, "reset_held");
    rst_n = 1'b1;

    // len 0, 5 passes after reset
    vec.delete();
    r(1,0,1,0,4, 0,0,0,0,0,0,0,0);
    r(0,0,1,0,4, 1,0,0,1,0,0,1,0);
    r(0,0,1,0,4, 1,0,0,1,0,1,1,0);
    r(0,0,1,0,4, 1,0,0,1,0,2,1,0);
    r(0,0,1,0,4, 1,0,0,1,0,3,1,0);
    r(0,0,1,0,4, 1,0,0,1,1,4,1,0);
    r(0,0,1,0,4, 0,0,0,0,0,0,0,1);
    r(0,0,1,0,4, 0,0,0,0,0,0,0,0);
    apply_rows();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
